// File: rtl/sodor_selfcomp_monitor_if.sv
// Observation bundle shared by the two Sodor core copies and the self-composition monitor.
// Latency: none, wires only. Backpressure: none, the channels are sampled every cycle.
// Signals: obs_valid_a/b (NUM_CH), obs_data_a/b (NUM_CH*CH_W, channel i at [i*CH_W +: CH_W]),
//          ch_mask (NUM_CH, 1 = channel compared). master drives, slave (the monitor) observes.
interface sodor_selfcomp_monitor_if #(
   parameter int NUM_CH = 4,
   parameter int CH_W   = 32
);
   logic [NUM_CH-1:0]      obs_valid_a;
   logic [NUM_CH-1:0]      obs_valid_b;
   logic [NUM_CH*CH_W-1:0] obs_data_a;
   logic [NUM_CH*CH_W-1:0] obs_data_b;
   logic [NUM_CH-1:0]      ch_mask;

   modport master (
      output obs_valid_a, obs_valid_b, obs_data_a, obs_data_b, ch_mask
   );

   modport slave (
      input obs_valid_a, obs_valid_b, obs_data_a, obs_data_b, ch_mask
   );
endinterface

// File: rtl/sodor_selfcomp_monitor.sv
// Sequencer and divergence checker for two-copy (self-composed) Sodor benches.
// Latency: diverge_now/check_fail combinational from the bus; sticky/first_div_* update at the next edge.
// Backpressure: none; every channel is compared every cycle, nothing is ever stalled.
// Ports: clk, reset (sync, active high, restarts the sequence); bus (slave: per-copy valid/data, ch_mask);
//        core_reset, assume_window, phase, cycle, done decode from registers only;
//        diverge_now, diverge_sticky, first_div_cycle, first_div_ch, check_fire, check_fail.
// Optional feature: define SELFCOMP_FORMAL_EN to emit the alignment assumes and the check assert.
module sodor_selfcomp_monitor #(
   parameter int NUM_CH     = 4,
   parameter int CH_W       = 32,
   parameter int CNT_W      = 5,
   parameter int RESET_CYC  = 2,
   parameter int ASSUME_CYC = 1,
   parameter int CHECK_CYC  = 14,
   localparam int IDX_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                  clk,
   input  logic                  reset,
   sodor_selfcomp_monitor_if.slave bus,
   output logic                  core_reset,
   output logic                  assume_window,
   output logic [1:0]            phase,
   output logic [CNT_W-1:0]      cycle,
   output logic [NUM_CH-1:0]     diverge_now,
   output logic [NUM_CH-1:0]     diverge_sticky,
   output logic [CNT_W-1:0]      first_div_cycle,
   output logic [IDX_W-1:0]      first_div_ch,
   output logic                  check_fire,
   output logic                  check_fail,
   output logic                  done
);

   typedef enum logic [1:0] {
      PH_RESET = 2'd0,
      PH_ALIGN = 2'd1,
      PH_RUN   = 2'd2,
      PH_DONE  = 2'd3
   } phase_e;

   // Last cycle spent in each phase; transitions fire on these so that a
   // saturated counter can never re-trigger or skip a phase change.
   localparam logic [CNT_W-1:0] RESET_END = CNT_W'(RESET_CYC - 1);
   localparam logic [CNT_W-1:0] ALIGN_END = CNT_W'(RESET_CYC + ASSUME_CYC - 1);
   localparam logic [CNT_W-1:0] CHECK_AT  = CNT_W'(CHECK_CYC);
   localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

   phase_e            state_q, state_d;
   logic [CNT_W-1:0]  cycle_q, cycle_d;
   logic [NUM_CH-1:0] sticky_q, sticky_d;
   logic [CNT_W-1:0]  first_cyc_q, first_cyc_d;
   logic [IDX_W-1:0]  first_ch_q, first_ch_d;
   logic [IDX_W-1:0]  low_idx;

   // Per-channel comparison; data only matters when both copies present a beat.
   always_comb begin
      diverge_now = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (state_q == PH_RUN && bus.ch_mask[i]) begin
            diverge_now[i] = (bus.obs_valid_a[i] ^ bus.obs_valid_b[i]) |
                             (bus.obs_valid_a[i] & bus.obs_valid_b[i] &
                              (bus.obs_data_a[i*CH_W +: CH_W] != bus.obs_data_b[i*CH_W +: CH_W]));
         end
      end
   end

   // Lowest diverging channel wins when several diverge in the same cycle.
   always_comb begin
      low_idx = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (diverge_now[i]) begin
            low_idx = IDX_W'(i);
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      cycle_d     = (cycle_q == CNT_MAX) ? cycle_q : cycle_q + CNT_W'(1);
      sticky_d    = sticky_q | diverge_now;
      first_cyc_d = first_cyc_q;
      first_ch_d  = first_ch_q;

      case (state_q)
         PH_RESET: if (cycle_q == RESET_END) state_d = PH_ALIGN;
         PH_ALIGN: if (cycle_q == ALIGN_END) state_d = PH_RUN;
         PH_RUN:   if (cycle_q == CHECK_AT)  state_d = PH_DONE;
         PH_DONE:  state_d = PH_DONE;
         default:  state_d = PH_RESET;
      endcase

      if (sticky_q == '0 && |diverge_now) begin
         first_cyc_d = cycle_q;
         first_ch_d  = low_idx;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= PH_RESET;
         cycle_q     <= '0;
         sticky_q    <= '0;
         first_cyc_q <= '0;
         first_ch_q  <= '0;
      end else begin
         state_q     <= state_d;
         cycle_q     <= cycle_d;
         sticky_q    <= sticky_d;
         first_cyc_q <= first_cyc_d;
         first_ch_q  <= first_ch_d;
      end
   end

   assign core_reset      = (state_q == PH_RESET);
   assign assume_window   = (state_q == PH_ALIGN);
   assign done            = (state_q == PH_DONE);
   assign phase           = state_q;
   assign cycle           = cycle_q;
   assign diverge_sticky  = sticky_q;
   assign first_div_cycle = first_cyc_q;
   assign first_div_ch    = first_ch_q;
   assign check_fire      = (state_q == PH_RUN) && (cycle_q == CHECK_AT);
   // Divergence seen in the check cycle itself also fails the check.
   assign check_fail      = check_fire && |(sticky_q | diverge_now);

`ifdef SELFCOMP_FORMAL_EN
   always_comb begin
      if (!reset && assume_window) begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (bus.ch_mask[i]) begin
               assume (bus.obs_valid_a[i] == bus.obs_valid_b[i] &&
                       bus.obs_data_a[i*CH_W +: CH_W] == bus.obs_data_b[i*CH_W +: CH_W]);
            end
         end
      end
      if (!reset && check_fire) begin
         assert (!check_fail);
      end
   end
`endif

endmodule

// File: tb/tb_sodor_selfcomp_monitor.sv
// Randomised scoreboard bench for sodor_selfcomp_monitor with default parameters.
// Latency: expected status pushed per cycle, popped and compared at the falling edge.
// Backpressure: none; check outcomes go to a separate queue popped on check_fire.
module tb_sodor_selfcomp_monitor;
   localparam int NUM_CH = 4;
   localparam int CH_W = 32;
   localparam int CNT_W = 5;
   localparam int RESET_CYC = 2;
   localparam int ASSUME_CYC = 1;
   localparam int CHECK_CYC = 14;
   localparam int CNT_SAT = (1 << CNT_W) - 1;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   sodor_selfcomp_monitor_if #(.NUM_CH(NUM_CH), .CH_W(CH_W)) bus ();

   logic              core_reset, assume_window, check_fire, check_fail, done;
   logic [1:0]        phase;
   logic [CNT_W-1:0]  cycle, first_div_cycle;
   logic [NUM_CH-1:0] diverge_now, diverge_sticky;
   logic [1:0]        first_div_ch;

   sodor_selfcomp_monitor #(
      .NUM_CH(NUM_CH), .CH_W(CH_W), .CNT_W(CNT_W), .RESET_CYC(RESET_CYC),
      .ASSUME_CYC(ASSUME_CYC), .CHECK_CYC(CHECK_CYC)
   ) dut (
      .clk(clk), .reset(reset), .bus(bus.slave),
      .core_reset(core_reset), .assume_window(assume_window), .phase(phase),
      .cycle(cycle), .diverge_now(diverge_now), .diverge_sticky(diverge_sticky),
      .first_div_cycle(first_div_cycle), .first_div_ch(first_div_ch),
      .check_fire(check_fire), .check_fail(check_fail), .done(done)
   );

   typedef struct {
      int ph; int cyc; int cr; int aw; int dn_done;
      int dn; int sticky; int fcyc; int fch; int fire; int fail;
   } exp_t;

   exp_t exp_q[$];
   int   chk_q[$];
   int   n_chk = 0;
   int   n_err = 0;

   // Reference model state: unsaturated time since reset release plus the record.
   int m_t = 0;
   int m_sticky = 0;
   int m_fcyc = 0;
   int m_fch = 0;
   bit prev_rst = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
      n_chk++;
      if (act !== exp_v) begin
         n_err++;
         $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp_v);
      end
   endtask

   function automatic int phase_of(input int t);
      if (t < RESET_CYC) return 0;
      if (t < RESET_CYC + ASSUME_CYC) return 1;
      if (t <= CHECK_CYC) return 2;
      return 3;
   endfunction

   // Drive one cycle and predict what the DUT shows during it.
   task automatic step(input bit rst_i, input logic [3:0] va, input logic [3:0] vb,
                       input logic [127:0] da, input logic [127:0] db, input logic [3:0] msk);
      exp_t e;
      int   dn;
      @(posedge clk);
      #1;
      reset = rst_i;
      bus.obs_valid_a = va;
      bus.obs_valid_b = vb;
      bus.obs_data_a  = da;
      bus.obs_data_b  = db;
      bus.ch_mask     = msk;
      if (rst_i) begin
         if (prev_rst) begin
            e = '{ph:0, cyc:0, cr:1, aw:0, dn_done:0, dn:0, sticky:0, fcyc:0, fch:0, fire:0, fail:0};
            exp_q.push_back(e);
         end
         m_t = 0; m_sticky = 0; m_fcyc = 0; m_fch = 0;
         prev_rst = 1'b1;
      end else begin
         prev_rst = 1'b0;
         e.ph      = phase_of(m_t);
         e.cyc     = (m_t > CNT_SAT) ? CNT_SAT : m_t;
         e.cr      = (e.ph == 0);
         e.aw      = (e.ph == 1);
         e.dn_done = (e.ph == 3);
         dn = 0;
         for (int i = 0; i < NUM_CH; i++) begin
            if (e.ph == 2 && msk[i] &&
                (va[i] != vb[i] || (va[i] && vb[i] && da[i*32 +: 32] != db[i*32 +: 32])))
               dn |= (1 << i);
         end
         e.dn     = dn;
         e.sticky = m_sticky;
         e.fcyc   = m_fcyc;
         e.fch    = m_fch;
         e.fire   = (e.ph == 2 && m_t == CHECK_CYC);
         e.fail   = e.fire && ((m_sticky | dn) != 0);
         exp_q.push_back(e);
         if (e.fire) chk_q.push_back(e.fail);
         if (m_sticky == 0 && dn != 0) begin
            m_fcyc = e.cyc;
            for (int i = NUM_CH - 1; i >= 0; i--) if (dn[i]) m_fch = i;
         end
         m_sticky |= dn;
         m_t++;
      end
   endtask

   // mode 0 identical, 1 valid skew ch1 @6, 2 data ch0/ch2 @5, 3 invisible/out-of-window
   // mismatches, 4 ch0 mismatch every cycle, 5 random flips with a mid-run mask change.
   task automatic run_seq(input int mode, input logic [3:0] mask_in, input int len, input int rst_at);
      logic [3:0]   va, vb, msk;
      logic [127:0] da, db;
      int           ch;
      msk = mask_in;
      step(1'b1, 4'h0, 4'h0, '0, '0, msk);
      step(1'b1, 4'h0, 4'h0, '0, '0, msk);
      for (int k = 0; k < len; k++) begin
         if (k == rst_at) begin
            step(1'b1, 4'h0, 4'h0, '0, '0, msk);
            step(1'b1, 4'h0, 4'h0, '0, '0, msk);
         end
         va = 4'($urandom);
         da = {$urandom, $urandom, $urandom, $urandom};
         vb = va;
         db = da;
         case (mode)
            1: if (m_t == 6) begin va[1] = 1'b1; vb[1] = 1'b0; end
            2: if (m_t == 5) begin
                  va[0] = 1'b1; vb[0] = 1'b1; va[2] = 1'b1; vb[2] = 1'b1;
                  da[31:0] = 32'h64; db[31:0] = 32'h68;
                  da[95:64] = 32'h64; db[95:64] = 32'h68;
               end
            3: begin
                  va[3] = 1'b0; vb[3] = 1'b0; db[127:96] = ~da[127:96];
                  if (m_t == 2 || m_t == 15) begin va[1] = 1'b1; vb[1] = 1'b0; end
               end
            4: begin va[0] = 1'b1; vb[0] = 1'b1; db[31:0] = ~da[31:0]; end
            5: begin
                  if (m_t == 10) msk = 4'($urandom);
                  if ($urandom_range(0, 7) == 0) begin
                     ch = $urandom_range(0, 3);
                     if ($urandom_range(0, 1) == 0) vb[ch] = ~vb[ch];
                     else db[ch*32 + $urandom_range(0, 31)] ^= 1'b1;
                  end
               end
            default: ;
         endcase
         step(1'b0, va, vb, da, db, msk);
      end
   endtask

   initial begin : monitor
      exp_t e;
      int   f;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("phase", 32'(phase), 32'(e.ph));
            chk("cycle", 32'(cycle), 32'(e.cyc));
            chk("core_reset", 32'(core_reset), 32'(e.cr));
            chk("assume_window", 32'(assume_window), 32'(e.aw));
            chk("done", 32'(done), 32'(e.dn_done));
            chk("diverge_now", 32'(diverge_now), 32'(e.dn));
            chk("diverge_sticky", 32'(diverge_sticky), 32'(e.sticky));
            chk("first_div_cycle", 32'(first_div_cycle), 32'(e.fcyc));
            chk("first_div_ch", 32'(first_div_ch), 32'(e.fch));
            chk("check_fire", 32'(check_fire), 32'(e.fire));
         end
         if (check_fire === 1'b1) begin
            if (chk_q.size() == 0) begin
               chk("unexpected_check_fire", 32'(check_fire), 32'd0);
            end else begin
               f = chk_q.pop_front();
               chk("check_fail", 32'(check_fail), 32'(f));
            end
         end
      end
   end

   initial begin : driver
      bus.obs_valid_a = '0;
      bus.obs_valid_b = '0;
      bus.obs_data_a  = '0;
      bus.obs_data_b  = '0;
      bus.ch_mask     = 4'hF;
      run_seq(0, 4'hF, 20, -1);
      run_seq(1, 4'hF, 20, -1);
      run_seq(2, 4'hF, 20, -1);
      run_seq(3, 4'hF, 20, -1);
      run_seq(4, 4'b1110, 20, -1);
      run_seq(4, 4'hF, 20, -1);
      run_seq(1, 4'hF, 25, 9);
      run_seq(0, 4'hF, 40, -1);
      for (int r = 0; r < 12; r++) run_seq(5, 4'($urandom), 20, -1);
      step(1'b1, 4'h0, 4'h0, '0, '0, 4'hF);
      @(negedge clk);
      @(negedge clk);
      chk("check_queue_drained", 32'(chk_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule
